// File: rtl/ti_simon_round_engine.sv
// Three-share threshold-implementation Simon round engine: holds masked (x, y),
// applies one masked round per accepted round-key beat, iterates ROUNDS times.
module ti_simon_round_engine #(
    parameter int WORD   = 16,
    parameter int ROUNDS = 32,
    parameter int ROT_A  = 1,
    parameter int ROT_B  = 8,
    parameter int ROT_C  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dec,
    input  logic [WORD-1:0] x_in_a,
    input  logic [WORD-1:0] x_in_b,
    input  logic [WORD-1:0] x_in_c,
    input  logic [WORD-1:0] y_in_a,
    input  logic [WORD-1:0] y_in_b,
    input  logic [WORD-1:0] y_in_c,
    input  logic            key_valid,
    output logic            key_ready,
    input  logic [WORD-1:0] key_a,
    input  logic [WORD-1:0] key_b,
    input  logic [WORD-1:0] key_c,
    output logic [WORD-1:0] x_out_a,
    output logic [WORD-1:0] x_out_b,
    output logic [WORD-1:0] x_out_c,
    output logic [WORD-1:0] y_out_a,
    output logic [WORD-1:0] y_out_b,
    output logic [WORD-1:0] y_out_c,
    output logic            busy,
    output logic            done,
    output logic [7:0]      round_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [7:0] LAST_IDX   = 8'(ROUNDS - 1);
    localparam logic [7:0] ROUNDS_IDX = 8'(ROUNDS);

    function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int unsigned r);
        logic [2*WORD-1:0] dbl;
        dbl = {v, v} << (r % WORD);
        return dbl[2*WORD-1:WORD];
    endfunction

    // Non-complete share of the Simon f function: touches only shares p and q.
    function automatic logic [WORD-1:0] f_share(input logic [WORD-1:0] p, input logic [WORD-1:0] q);
        return rol(p, ROT_C)
             ^ (rol(p, ROT_A) & rol(p, ROT_B))
             ^ (rol(p, ROT_A) & rol(q, ROT_B))
             ^ (rol(q, ROT_A) & rol(p, ROT_B));
    endfunction

    state_e          state_q;
    logic            dec_q;
    logic [7:0]      round_idx_q;
    logic            busy_q;
    logic            done_q;
    logic            key_ready_q;

    logic [WORD-1:0] x_a_q, x_b_q, x_c_q, y_a_q, y_b_q, y_c_q;
    logic [WORD-1:0] x_a_d, x_b_d, x_c_d, y_a_d, y_b_d, y_c_d;
    logic [WORD-1:0] src_a_s, src_b_s, src_c_s;
    logic [WORD-1:0] oth_a_s, oth_b_s, oth_c_s;
    logic [WORD-1:0] mix_a_s, mix_b_s, mix_c_s;
    logic            load_s;
    logic            fire_s;

    assign load_s = (state_q == S_IDLE) & start;
    assign fire_s = (state_q == S_RUN) & key_valid & key_ready_q;

    // f is applied to the half that moves across: x when encrypting, y when decrypting.
    always_comb begin
        if (dec_q) begin
            src_a_s = y_a_q;
            src_b_s = y_b_q;
            src_c_s = y_c_q;
            oth_a_s = x_a_q;
            oth_b_s = x_b_q;
            oth_c_s = x_c_q;
        end else begin
            src_a_s = x_a_q;
            src_b_s = x_b_q;
            src_c_s = x_c_q;
            oth_a_s = y_a_q;
            oth_b_s = y_b_q;
            oth_c_s = y_c_q;
        end
        mix_a_s = oth_a_s ^ key_a ^ f_share(src_a_s, src_b_s);
        mix_b_s = oth_b_s ^ key_b ^ f_share(src_b_s, src_c_s);
        mix_c_s = oth_c_s ^ key_c ^ f_share(src_c_s, src_a_s);
    end

    // Next share state: load on start, one round per fired beat, otherwise hold.
    always_comb begin
        x_a_d = x_a_q;
        x_b_d = x_b_q;
        x_c_d = x_c_q;
        y_a_d = y_a_q;
        y_b_d = y_b_q;
        y_c_d = y_c_q;
        if (load_s) begin
            x_a_d = x_in_a;
            x_b_d = x_in_b;
            x_c_d = x_in_c;
            y_a_d = y_in_a;
            y_b_d = y_in_b;
            y_c_d = y_in_c;
        end else if (fire_s) begin
            if (dec_q) begin
                x_a_d = src_a_s;
                x_b_d = src_b_s;
                x_c_d = src_c_s;
                y_a_d = mix_a_s;
                y_b_d = mix_b_s;
                y_c_d = mix_c_s;
            end else begin
                x_a_d = mix_a_s;
                x_b_d = mix_b_s;
                x_c_d = mix_c_s;
                y_a_d = src_a_s;
                y_b_d = src_b_s;
                y_c_d = src_c_s;
            end
        end else begin
            x_a_d = x_a_q;
            y_a_d = y_a_q;
        end
    end

    // Share state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_a_q <= {WORD{1'b0}};
            x_b_q <= {WORD{1'b0}};
            x_c_q <= {WORD{1'b0}};
            y_a_q <= {WORD{1'b0}};
            y_b_q <= {WORD{1'b0}};
            y_c_q <= {WORD{1'b0}};
        end else begin
            x_a_q <= x_a_d;
            x_b_q <= x_b_d;
            x_c_q <= x_c_d;
            y_a_q <= y_a_d;
            y_b_q <= y_b_d;
            y_c_q <= y_c_d;
        end
    end

    // Control FSM with registered busy/done/key_ready and round counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dec_q       <= 1'b0;
            round_idx_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q     <= S_RUN;
                        dec_q       <= dec;
                        round_idx_q <= 8'd0;
                        busy_q      <= 1'b1;
                        key_ready_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (fire_s) begin
                        if (round_idx_q < ROUNDS_IDX) begin
                            round_idx_q <= round_idx_q + 8'd1;
                        end else begin
                            round_idx_q <= round_idx_q;
                        end
                        if (round_idx_q == LAST_IDX) begin
                            state_q     <= S_DONE;
                            busy_q      <= 1'b0;
                            key_ready_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    key_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign x_out_a   = x_a_q;
    assign x_out_b   = x_b_q;
    assign x_out_c   = x_c_q;
    assign y_out_a   = y_a_q;
    assign y_out_b   = y_b_q;
    assign y_out_c   = y_c_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign key_ready = key_ready_q;
    assign round_idx = round_idx_q;

endmodule
